// File: rtl/dec_n_seq.sv
// Registered N-to-2^N one-hot decoder with a step-driven scan sequencer.
// Hold mode presents one select; scan mode walks the hot bit under a step handshake.
module dec_n_seq #(
    parameter int N    = 3,
    parameter bit WRAP = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        sel,
    input  logic                load,
    input  logic                scan_start,
    input  logic                step,
    input  logic                clr,
    output logic [(1<<N)-1:0]   out,
    output logic [N-1:0]        idx,
    output logic                valid,
    output logic                busy,
    output logic                done
);

    localparam int W = 1 << N;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t       state;
    logic [N-1:0] start_idx;
    logic [N-1:0] next_idx;
    logic [N-1:0] last_idx;

    function automatic logic [W-1:0] one_hot(input logic [N-1:0] i);
        logic [W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // In wrap mode the scan ends one index before where it began, covering all 2^N.
    assign next_idx = idx + ONE;
    assign last_idx = WRAP ? (start_idx - ONE) : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_idx <= '0;
            idx       <= '0;
            out       <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (clr) begin
                        state <= IDLE;
                        idx   <= '0;
                        out   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (scan_start) begin
                        state     <= SCAN;
                        start_idx <= sel;
                        idx       <= sel;
                        out       <= one_hot(sel);
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                    end else if (load) begin
                        state <= HOLD;
                        idx   <= sel;
                        out   <= one_hot(sel);
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                SCAN: begin
                    // load and scan_start are deliberately ignored while scanning.
                    if (clr) begin
                        state <= IDLE;
                        idx   <= '0;
                        out   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (step) begin
                        if (idx == last_idx) begin
                            state <= IDLE;
                            idx   <= '0;
                            out   <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= next_idx;
                            out <= one_hot(next_idx);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    out   <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_n_seq.sv
// Directed bench for dec_n_seq: one WRAP=0 and one WRAP=1 instance share stimulus,
// expected outputs are queued per step and checked after each rising edge.
module tb_dec_n_seq;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic       load;
    logic       scan_start;
    logic       step;
    logic       clr;

    logic [7:0] out0, out1;
    logic [2:0] idx0, idx1;
    logic       valid0, valid1, busy0, busy1, done0, done1;

    int tests_run  = 0;
    int fail_count = 0;

    typedef struct {
        int         dut;
        logic [7:0] out;
        logic [2:0] idx;
        logic       valid;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    dec_n_seq #(.N(3), .WRAP(1'b0)) u_nowrap (
        .clk(clk), .rst(rst), .sel(sel), .load(load), .scan_start(scan_start),
        .step(step), .clr(clr), .out(out0), .idx(idx0), .valid(valid0),
        .busy(busy0), .done(done0)
    );

    dec_n_seq #(.N(3), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .sel(sel), .load(load), .scan_start(scan_start),
        .step(step), .clr(clr), .out(out1), .idx(idx1), .valid(valid1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] observe(input int d);
        if (d == 0) return {out0, idx0, valid0, busy0, done0};
        return {out1, idx1, valid1, busy1, done1};
    endfunction

    task automatic push_exp(input int d, input logic [7:0] o, input logic [2:0] i,
                            input logic v, input logic b, input logic dn, input string tag);
        exp_t e;
        e.dut = d; e.out = o; e.idx = i; e.valid = v; e.busy = b; e.done = dn; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_both(input logic [7:0] o, input logic [2:0] i,
                             input logic v, input logic b, input logic dn, input string tag);
        push_exp(0, o, i, v, b, dn, tag);
        push_exp(1, o, i, v, b, dn, tag);
    endtask

    task automatic push_idle(input string tag);
        push_both(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic ld, input logic ss,
                                 input logic st, input logic cl);
        @(negedge clk);
        sel        = s;
        load       = ld;
        scan_start = ss;
        step       = st;
        clr        = cl;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [13:0] got;
        logic [13:0] want;
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            got  = observe(e.dut);
            want = {e.out, e.idx, e.valid, e.busy, e.done};
            tests_run++;
            assert (got === want) else begin
                fail_count++;
                $error("[TB] FAIL %s dut%0d: observed out=%h idx=%0d valid=%b busy=%b done=%b, expected out=%h idx=%0d valid=%b busy=%b done=%b",
                       e.tag, e.dut, got[13:6], got[5:3], got[2], got[1], got[0],
                       want[13:6], want[5:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; sel = '0; load = 0; scan_start = 0; step = 0; clr = 0;
        repeat (2) @(posedge clk);
        #1;
        push_idle("reset_state");
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Load and hold
        applyStimulus(3'd5, 1, 0, 0, 0);
        push_both(8'h20, 3'd5, 1, 0, 0, "load_sel5");
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'd0, 0, 0, 0, 0);
            push_exp(0, 8'h20, 3'd5, 1, 0, 0, "hold_sel5");
            tick();
        end
        applyStimulus(3'd0, 0, 0, 1, 1);
        push_idle("clr_from_hold");
        tick();

        // Priority
        applyStimulus(3'd5, 1, 0, 0, 0);
        push_both(8'h20, 3'd5, 1, 0, 0, "prio_setup_hold");
        tick();
        applyStimulus(3'd3, 1, 1, 0, 1);
        push_idle("prio_clr_wins");
        tick();
        applyStimulus(3'd1, 1, 1, 0, 0);
        push_both(8'h02, 3'd1, 1, 1, 0, "prio_scan_over_load");
        tick();
        applyStimulus(3'd7, 1, 0, 0, 0);
        push_both(8'h02, 3'd1, 1, 1, 0, "load_ignored_in_scan");
        tick();
        applyStimulus(3'd4, 0, 1, 0, 0);
        push_both(8'h02, 3'd1, 1, 1, 0, "scan_start_ignored_in_scan");
        tick();
        applyStimulus(3'd0, 0, 0, 0, 1);
        push_idle("clr_in_scan");
        tick();
        applyStimulus(3'd0, 0, 0, 0, 0);
        push_idle("clr_in_scan_no_done");
        tick();

        // WRAP=0 scan from 5 with a 3-cycle stall at idx 6
        applyStimulus(3'd5, 0, 1, 1, 0);
        push_both(8'h20, 3'd5, 1, 1, 0, "scan_first_5");
        tick();
        applyStimulus(3'd0, 0, 0, 1, 0);
        push_both(8'h40, 3'd6, 1, 1, 0, "scan_step_6");
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd0, 0, 0, 0, 0);
            push_both(8'h40, 3'd6, 1, 1, 0, "stall_6");
            tick();
        end
        applyStimulus(3'd0, 0, 0, 1, 0);
        push_both(8'h80, 3'd7, 1, 1, 0, "resume_7");
        tick();
        applyStimulus(3'd0, 0, 0, 1, 0);
        push_exp(0, 8'h00, 3'd0, 0, 0, 1, "nowrap_done");
        push_exp(1, 8'h01, 3'd0, 1, 1, 0, "wrap_passes_0");
        tick();
        applyStimulus(3'd2, 1, 0, 0, 0);
        push_exp(0, 8'h04, 3'd2, 1, 0, 0, "load_in_done_cycle");
        push_exp(1, 8'h01, 3'd0, 1, 1, 0, "wrap_stall_ignores_load");
        tick();
        applyStimulus(3'd0, 0, 0, 0, 1);
        push_idle("clr_after_wrap0");
        tick();

        // Single-index scan at the top index
        applyStimulus(3'd7, 0, 1, 1, 0);
        push_both(8'h80, 3'd7, 1, 1, 0, "scan_first_7");
        tick();
        applyStimulus(3'd0, 0, 0, 1, 0);
        push_exp(0, 8'h00, 3'd0, 0, 0, 1, "single_index_done");
        push_exp(1, 8'h01, 3'd0, 1, 1, 0, "wrap_from7_to0");
        tick();
        applyStimulus(3'd0, 0, 0, 0, 1);
        push_idle("clr_after_single");
        tick();

        // WRAP=1 scan from 6 with step held high
        applyStimulus(3'd6, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            logic [2:0] wi;
            wi = 3'(6 + i);
            if (i < 8) push_exp(1, 8'h01 << wi, wi, 1, 1, 0, "wrap_walk");
            else       push_exp(1, 8'h00, 3'd0, 0, 0, 1, "wrap_done");
            if (i == 0)      push_exp(0, 8'h40, 3'd6, 1, 1, 0, "nowrap_from6_6");
            else if (i == 1) push_exp(0, 8'h80, 3'd7, 1, 1, 0, "nowrap_from6_7");
            else if (i == 2) push_exp(0, 8'h00, 3'd0, 0, 0, 1, "nowrap_from6_done");
            else             push_exp(0, 8'h00, 3'd0, 0, 0, 0, "step_no_effect_idle");
            tick();
            if (i == 0) applyStimulus(3'd0, 0, 0, 1, 0);
        end
        applyStimulus(3'd0, 0, 0, 0, 0);
        push_idle("done_single_pulse");
        tick();

        // Asynchronous reset mid-scan
        applyStimulus(3'd2, 0, 1, 1, 0);
        push_both(8'h04, 3'd2, 1, 1, 0, "rst_scan_2");
        tick();
        applyStimulus(3'd0, 0, 0, 1, 0);
        push_both(8'h08, 3'd3, 1, 1, 0, "rst_scan_3");
        tick();
        push_both(8'h10, 3'd4, 1, 1, 0, "rst_scan_4");
        tick();
        #2;
        rst = 1'b1;
        #1;
        push_idle("async_rst_immediate");
        checkOutput();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_idle("idle_after_rst");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
